// File: rtl/pmc_pkg.sv
// pmc_pkg: shared definitions for the performance-monitoring counter array.
// Holds the event-class index enum (one entry per instruction class), the
// default positions of the cycle and retired counters in read-address order,
// helpers that compute those positions for an arbitrary NUM_CNT, and the
// snapshot FSM state type.
package pmc_pkg;

  // One event strobe per instruction class; the value is the counter index.
  typedef enum logic [4:0] {
    ADD, SUB, ADDI, ADD_FP, MUL_FP, VADD_FP, VMUL_FP, VSUM_FP, VSET_FP,
    SW, LW, SW_FP, LW_FP, VST, VLD, BEQ, BLT, J
  } pmcEvent_e;

  localparam int PMC_NUM_EVENTS = 18;
  localparam int CYCLE_IDX      = PMC_NUM_EVENTS;
  localparam int RETIRED_IDX    = PMC_NUM_EVENTS + 1;

  // The cycle and retired counters always sit right after the event counters.
  function automatic int cycleIdx(input int numCnt);
    return numCnt;
  endfunction

  function automatic int retiredIdx(input int numCnt);
    return numCnt + 1;
  endfunction

  typedef enum logic {
    SNAP_IDLE,
    SNAP_DONE
  } snapState_e;

endpackage

// File: rtl/pmc_counter.sv
// pmc_counter: one performance counter plus its sticky overflow flag.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   inc      add one this cycle
//   clr      synchronous clear of count and overflow flag (beats inc)
//   count_o  current count
//   ovf_o    sticky overflow flag
// Parameters: CNT_W (width), SATURATE (0 = wrap to zero, 1 = hold all-ones).
module pmc_counter #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  // An increment from all-ones is the overflow event; in saturating mode the
  // count simply stays at all-ones, so later increments change nothing.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (inc) begin
      if (&count_q) begin
        ovf_d   = 1'b1;
        count_d = SATURATE ? '1 : '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/pmc_array.sv
// pmc_array: performance-monitoring counter array.
// NUM_CNT event counters, a cycle counter (index NUM_CNT) and a retired
// counter (index NUM_CNT+1), each with a sticky overflow flag. A snapshot
// copies all live counters into a shadow bank; reads (1-cycle latency) are
// served from the shadow bank only.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   run_i                 global count enable
//   event_i, cnt_en_i     per-class event strobes and enable mask
//   retire_i              instruction-retired strobe
//   clear_i               synchronous clear of live counters and ovf flags
//   snap_req_i            snapshot request; snap_done_o pulses one cycle later
//   rd_en_i, rd_addr_i    read strobe and shadow index
//   rd_data_o, rd_valid_o read result, one cycle after rd_en_i
//   ovf_o                 sticky overflow flags in read-address order
//   ovf_mask_i, irq_o     overflow interrupt mask and registered interrupt,
//                         present only when PMC_OVF_IRQ_EN is defined
module pmc_array
  import pmc_pkg::*;
#(
  parameter int  NUM_CNT  = 18,
  parameter int  CNT_W    = 32,
  parameter bit  SATURATE = 1'b0,
  localparam int ADDR_W   = $clog2(NUM_CNT + 2)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_i,
  input  logic [NUM_CNT-1:0] event_i,
  input  logic [NUM_CNT-1:0] cnt_en_i,
  input  logic               retire_i,
  input  logic               clear_i,
  input  logic               snap_req_i,
  output logic               snap_done_o,
  input  logic               rd_en_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               rd_valid_o,
  output logic [NUM_CNT+1:0] ovf_o
`ifdef PMC_OVF_IRQ_EN
  ,
  input  logic [NUM_CNT+1:0] ovf_mask_i,
  output logic               irq_o
`endif
);

  localparam int TOTAL   = NUM_CNT + 2;
  localparam int CYC_POS = cycleIdx(NUM_CNT);
  localparam int RET_POS = retiredIdx(NUM_CNT);

  logic [TOTAL-1:0] incVec;
  logic [TOTAL-1:0] ovfVec;
  logic [CNT_W-1:0] liveCnt  [TOTAL];
  logic [CNT_W-1:0] shadow_q [TOTAL];
  snapState_e       snapState_q;
  logic             snapDone_q;
  logic [CNT_W-1:0] rdData_q;
  logic             rdValid_q;

  assign incVec[NUM_CNT-1:0] = {NUM_CNT{run_i}} & cnt_en_i & event_i;
  assign incVec[CYC_POS]     = run_i;
  assign incVec[RET_POS]     = run_i & retire_i;

  for (genvar g = 0; g < TOTAL; g++) begin : gCnt
    pmc_counter #(
      .CNT_W   (CNT_W),
      .SATURATE(SATURATE)
    ) uCnt (
      .clk    (clk),
      .reset  (reset),
      .inc    (incVec[g]),
      .clr    (clear_i),
      .count_o(liveCnt[g]),
      .ovf_o  (ovfVec[g])
    );
  end

  // Snapshot FSM: the shadow bank samples the live counters at the request
  // edge, so it sees pre-increment and pre-clear values. Requests arriving
  // while DONE is showing are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snapState_q <= SNAP_IDLE;
      snapDone_q  <= 1'b0;
      for (int i = 0; i < TOTAL; i++) shadow_q[i] <= '0;
    end else begin
      snapDone_q <= 1'b0;
      case (snapState_q)
        SNAP_IDLE: begin
          if (snap_req_i) begin
            for (int i = 0; i < TOTAL; i++) shadow_q[i] <= liveCnt[i];
            snapState_q <= SNAP_DONE;
            snapDone_q  <= 1'b1;
          end
        end
        SNAP_DONE: snapState_q <= SNAP_IDLE;
        default:   snapState_q <= SNAP_IDLE;
      endcase
    end
  end

  // Read port: the shadow bank is sampled before any same-edge snapshot
  // update lands. Addresses past the retired counter return zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      rdValid_q <= rd_en_i;
      if (rd_en_i) begin
        if (int'(rd_addr_i) < TOTAL) rdData_q <= shadow_q[rd_addr_i];
        else                         rdData_q <= '0;
      end
    end
  end

  assign snap_done_o = snapDone_q;
  assign rd_data_o   = rdData_q;
  assign rd_valid_o  = rdValid_q;
  assign ovf_o       = ovfVec;

`ifdef PMC_OVF_IRQ_EN
  logic irq_q;

  // Interrupt is registered from the already-registered flags, so it rises
  // one cycle after a masked overflow flag sets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= |(ovfVec & ovf_mask_i);
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_pmc_array.sv
// tb_pmc_array: self-checking bench for pmc_array. Three instances share one
// stimulus stream: a default 32-bit wrapping array, an 8-bit wrapping array
// and an 8-bit saturating array. A behavioural model of counts, shadows and
// flags predicts every output each cycle; hand sequences add fixed expected
// values for the key scenarios. Interrupt checks are active when
// PMC_OVF_IRQ_EN is defined.
module tb_pmc_array;
  import pmc_pkg::*;

  localparam int NC  = 18;
  localparam int TOT = NC + 2;
  localparam int AW  = $clog2(TOT);

  typedef struct {
    bit          run;
    bit [NC-1:0] ev;
    bit [NC-1:0] en;
    bit          ret;
    bit          clr;
    bit          snap;
    bit          rdEn;
    bit [AW-1:0] addr;
    bit [TOT-1:0] mask;
  } stim_t;

  typedef struct {
    stim_t  s;
    bit     expValid;
    longint expData;
    bit     expDone;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic run, ret, clr, snap, rdEn;
  logic [NC-1:0]  ev, en;
  logic [AW-1:0]  addr;
  logic [TOT-1:0] mask;

  logic [31:0] rdDataA;
  logic [7:0]  rdDataW, rdDataS;
  logic        rdValidA, rdValidW, rdValidS;
  logic        doneA, doneW, doneS;
  logic [TOT-1:0] ovfA, ovfW, ovfS;
`ifdef PMC_OVF_IRQ_EN
  logic irqA, irqW, irqS;
`endif

  int nCompared = 0;
  int nFailed   = 0;

  always #5 clk = ~clk;

  pmc_array #(.NUM_CNT(NC), .CNT_W(32), .SATURATE(1'b0)) dutA (
    .clk(clk), .reset(reset), .run_i(run), .event_i(ev), .cnt_en_i(en),
    .retire_i(ret), .clear_i(clr), .snap_req_i(snap), .snap_done_o(doneA),
    .rd_en_i(rdEn), .rd_addr_i(addr), .rd_data_o(rdDataA),
    .rd_valid_o(rdValidA), .ovf_o(ovfA)
`ifdef PMC_OVF_IRQ_EN
    , .ovf_mask_i(mask), .irq_o(irqA)
`endif
  );

  pmc_array #(.NUM_CNT(NC), .CNT_W(8), .SATURATE(1'b0)) dutW (
    .clk(clk), .reset(reset), .run_i(run), .event_i(ev), .cnt_en_i(en),
    .retire_i(ret), .clear_i(clr), .snap_req_i(snap), .snap_done_o(doneW),
    .rd_en_i(rdEn), .rd_addr_i(addr), .rd_data_o(rdDataW),
    .rd_valid_o(rdValidW), .ovf_o(ovfW)
`ifdef PMC_OVF_IRQ_EN
    , .ovf_mask_i(mask), .irq_o(irqW)
`endif
  );

  pmc_array #(.NUM_CNT(NC), .CNT_W(8), .SATURATE(1'b1)) dutS (
    .clk(clk), .reset(reset), .run_i(run), .event_i(ev), .cnt_en_i(en),
    .retire_i(ret), .clear_i(clr), .snap_req_i(snap), .snap_done_o(doneS),
    .rd_en_i(rdEn), .rd_addr_i(addr), .rd_data_o(rdDataS),
    .rd_valid_o(rdValidS), .ovf_o(ovfS)
`ifdef PMC_OVF_IRQ_EN
    , .ovf_mask_i(mask), .irq_o(irqS)
`endif
  );

  // Reference model state, one slot per instance.
  int           cw  [3] = '{32, 8, 8};
  bit           sat [3] = '{1'b0, 1'b0, 1'b1};
  longint       mCnt[3][TOT];
  longint       mSh [3][TOT];
  bit [TOT-1:0] mOvf[3];
  bit           mBusy;
  bit           expValid, expDone;
  longint       expRd [3];
  bit           expIrq[3];

  // Compares one actual value against its required value.
  function automatic void cmp(input string name, input longint act, input longint req);
    nCompared++;
    if (act != req) begin
      nFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  function automatic void modelReset();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < TOT; i++) begin
        mCnt[c][i] = 0;
        mSh[c][i]  = 0;
      end
      mOvf[c]   = '0;
      expRd[c]  = 0;
      expIrq[c] = 1'b0;
    end
    mBusy    = 1'b0;
    expValid = 1'b0;
    expDone  = 1'b0;
  endfunction

  // Applies the counting, snapshot and read rules for one clock edge.
  function automatic void modelEdge(input stim_t s);
    bit take;
    take = s.snap && !mBusy;
    for (int c = 0; c < 3; c++) begin
      longint maxv;
      maxv = (longint'(1) << cw[c]) - 1;
      if (s.rdEn) expRd[c] = (int'(s.addr) < TOT) ? mSh[c][s.addr] : 0;
      expIrq[c] = |(mOvf[c] & s.mask);
      if (take) for (int i = 0; i < TOT; i++) mSh[c][i] = mCnt[c][i];
      for (int i = 0; i < TOT; i++) begin
        bit inc;
        if (i < NC)       inc = s.run & s.en[i] & s.ev[i];
        else if (i == NC) inc = s.run;
        else              inc = s.run & s.ret;
        if (s.clr) begin
          mCnt[c][i] = 0;
          mOvf[c][i] = 1'b0;
        end else if (inc) begin
          if (mCnt[c][i] == maxv) begin
            mOvf[c][i] = 1'b1;
            mCnt[c][i] = sat[c] ? maxv : 0;
          end else begin
            mCnt[c][i] = mCnt[c][i] + 1;
          end
        end
      end
    end
    expValid = s.rdEn;
    expDone  = take;
    mBusy    = take;
  endfunction

  task automatic checkOutput();
    longint rd [3];
    longint vld[3];
    longint dn [3];
    longint ov [3];
    rd[0] = longint'(rdDataA);  rd[1] = longint'(rdDataW);  rd[2] = longint'(rdDataS);
    vld[0] = longint'(rdValidA); vld[1] = longint'(rdValidW); vld[2] = longint'(rdValidS);
    dn[0] = longint'(doneA);    dn[1] = longint'(doneW);    dn[2] = longint'(doneS);
    ov[0] = longint'(ovfA);     ov[1] = longint'(ovfW);     ov[2] = longint'(ovfS);
    for (int c = 0; c < 3; c++) begin
      cmp($sformatf("rd_valid[dut%0d]", c), vld[c], longint'(expValid));
      if (expValid) cmp($sformatf("rd_data[dut%0d]", c), rd[c], expRd[c]);
      cmp($sformatf("snap_done[dut%0d]", c), dn[c], longint'(expDone));
      cmp($sformatf("ovf[dut%0d]", c), ov[c], longint'(mOvf[c]));
    end
`ifdef PMC_OVF_IRQ_EN
    cmp("irq[dut0]", longint'(irqA), longint'(expIrq[0]));
    cmp("irq[dut1]", longint'(irqW), longint'(expIrq[1]));
    cmp("irq[dut2]", longint'(irqS), longint'(expIrq[2]));
`endif
  endtask

  // Drives one cycle of stimulus, advances the model at the edge and checks
  // the outputs shortly after it.
  task automatic applyStimulus(input stim_t s);
    run = s.run; ev = s.ev; en = s.en; ret = s.ret; clr = s.clr;
    snap = s.snap; rdEn = s.rdEn; addr = s.addr; mask = s.mask;
    @(posedge clk);
    modelEdge(s);
    #1;
    checkOutput();
  endtask

  function automatic stim_t mk(input bit r, input bit [NC-1:0] e, input bit rt,
                               input bit cl, input bit sn, input bit rd, input int a);
    stim_t s;
    s.run = r; s.ev = e; s.en = '1; s.ret = rt; s.clr = cl; s.snap = sn;
    s.rdEn = rd; s.addr = AW'(a); s.mask = '0;
    return s;
  endfunction

  task automatic checkAllZero(input string tag);
    cmp({tag, "_valid"}, longint'(rdValidA | rdValidW | rdValidS), 0);
    cmp({tag, "_data"}, longint'(rdDataA) + longint'(rdDataW) + longint'(rdDataS), 0);
    cmp({tag, "_done"}, longint'(doneA | doneW | doneS), 0);
    cmp({tag, "_ovf"}, longint'(ovfA | ovfW | ovfS), 0);
`ifdef PMC_OVF_IRQ_EN
    cmp({tag, "_irq"}, longint'(irqA | irqW | irqS), 0);
`endif
  endtask

  task automatic readBack(input int a);
    applyStimulus(mk(0, '0, 0, 0, 0, 1, a));
  endtask

  initial begin
    vec_t  tbl[$];
    stim_t s;
    bit [NC-1:0] allEv;
    bit [NC-1:0] ev0, ev1, ev2, ev3;
    allEv = '1;
    ev0 = NC'(1) << int'(ADD);
    ev1 = NC'(1) << int'(SUB);
    ev2 = NC'(1) << int'(ADDI);
    ev3 = NC'(1) << int'(ADD_FP);

    // Table: 20 running cycles, 7 ADD_FP events, 12 retirements, snapshot,
    // then reads of counter 3, cycle, retired and two out-of-range slots.
    tbl.push_back('{mk(0, '0, 0, 1, 0, 0, 0), 0, 0, 0});
    for (int i = 0; i < 20; i++)
      tbl.push_back('{mk(1, (i % 3 == 0) ? ev3 : '0, i < 12, 0, 0, 0, 0), 0, 0, 0});
    tbl.push_back('{mk(0, '0, 0, 0, 1, 0, 0), 0, 0, 1});
    tbl.push_back('{mk(0, '0, 0, 0, 0, 1, 3), 1, 7, 0});
    tbl.push_back('{mk(0, '0, 0, 0, 0, 1, CYCLE_IDX), 1, 20, 0});
    tbl.push_back('{mk(0, '0, 0, 0, 0, 1, RETIRED_IDX), 1, 12, 0});
    tbl.push_back('{mk(0, '0, 0, 0, 0, 1, TOT), 1, 0, 0});
    tbl.push_back('{mk(0, '0, 0, 0, 0, 1, (1 << AW) - 1), 1, 0, 0});

    s = mk(0, '0, 0, 0, 0, 0, 0);
    run = 0; ev = '0; en = '1; ret = 0; clr = 0; snap = 0; rdEn = 0;
    addr = '0; mask = '0;
    reset = 1'b0;
    modelReset();
    #1;
    checkAllZero("reset_state");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].s);
      cmp($sformatf("tbl%0d_valid", i), longint'(rdValidA), longint'(tbl[i].expValid));
      if (tbl[i].expValid) cmp($sformatf("tbl%0d_data", i), longint'(rdDataA), tbl[i].expData);
      cmp($sformatf("tbl%0d_done", i), longint'(doneA), longint'(tbl[i].expDone));
    end

    // Reset in the middle of counting: everything drops at once.
    applyStimulus(mk(0, '0, 0, 1, 0, 0, 0));
    repeat (5) applyStimulus(mk(1, allEv, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, '0, 0, 0, 1, 0, 0));
    readBack(0);
    cmp("pre_reset_cnt0", longint'(rdDataA), 5);
    applyStimulus(s);
    readBack(0);
    #2;
    reset = 1'b0;
    #1;
    checkAllZero("async_reset");
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) applyStimulus(mk(1, ev0, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, '0, 0, 0, 1, 0, 0));
    readBack(0);
    cmp("post_reset_cnt0", longint'(rdDataA), 3);
    readBack(CYCLE_IDX);
    cmp("post_reset_cycle", longint'(rdDataA), 3);

    // Per-counter enable mask and global run gating.
    applyStimulus(mk(0, '0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      s = mk(i < 4, allEv, 1, 0, 0, 0, 0);
      s.en[int'(ADD_FP)] = 1'b0;
      applyStimulus(s);
    end
    applyStimulus(mk(0, '0, 0, 0, 1, 0, 0));
    readBack(3);
    cmp("masked_cnt3", longint'(rdDataA), 0);
    readBack(0);
    cmp("enabled_cnt0", longint'(rdDataA), 4);
    readBack(CYCLE_IDX);
    cmp("gated_cycle", longint'(rdDataA), 4);
    readBack(RETIRED_IDX);
    cmp("gated_retired", longint'(rdDataA), 4);

    // Overflow: wrap versus saturate on 8-bit counters.
    applyStimulus(mk(0, '0, 0, 1, 0, 0, 0));
    repeat (256) applyStimulus(mk(1, ev0, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, '0, 0, 0, 1, 0, 0));
    readBack(0);
    cmp("wrap256_data", longint'(rdDataW), 0);
    cmp("wrap256_ovf0", longint'(ovfW[0]), 1);
    cmp("sat256_data", longint'(rdDataS), 255);
    cmp("wide256_data", longint'(rdDataA), 256);
    cmp("wide256_ovf0", longint'(ovfA[0]), 0);
    repeat (44) applyStimulus(mk(1, ev0, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, '0, 0, 0, 1, 0, 0));
    readBack(0);
    cmp("sat300_data", longint'(rdDataS), 255);
    cmp("sat300_ovf0", longint'(ovfS[0]), 1);
    cmp("wrap300_data", longint'(rdDataW), 44);

    // Clear together with snapshot, read on the snapshot edge, and a request
    // during DONE that must be dropped.
    applyStimulus(mk(0, '0, 0, 1, 0, 0, 0));
    repeat (4) applyStimulus(mk(1, ev1, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, '0, 0, 0, 1, 0, 0));
    repeat (5) applyStimulus(mk(1, ev1, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, '0, 0, 1, 1, 1, 1));
    cmp("snapedge_old_shadow", longint'(rdDataA), 4);
    cmp("clrsnap_done", longint'(doneA), 1);
    applyStimulus(mk(0, '0, 0, 0, 1, 1, 1));
    cmp("clrsnap_shadow", longint'(rdDataA), 9);
    cmp("done_one_cycle", longint'(doneA), 0);
    readBack(1);
    cmp("done_req_ignored", longint'(rdDataA), 9);
    cmp("no_second_done", longint'(doneA), 0);
    applyStimulus(mk(0, '0, 0, 0, 1, 0, 0));
    readBack(1);
    cmp("live_cleared", longint'(rdDataA), 0);

`ifdef PMC_OVF_IRQ_EN
    // Interrupt masking on the 8-bit wrapping instance.
    applyStimulus(mk(0, '0, 0, 1, 0, 0, 0));
    repeat (256) applyStimulus(mk(1, ev2, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, '0, 0, 0, 0, 0, 0));
    cmp("irq_ovf2_set", longint'(ovfW[2]), 1);
    cmp("irq_masked", longint'(irqW), 0);
    s = mk(0, '0, 0, 0, 0, 0, 0);
    s.mask[2] = 1'b1;
    applyStimulus(s);
    cmp("irq_unmasked", longint'(irqW), 1);
    s.clr = 1'b1;
    applyStimulus(s);
    s.clr = 1'b0;
    applyStimulus(s);
    cmp("irq_after_clear", longint'(irqW), 0);
`endif

    // Randomised traffic against the model.
    applyStimulus(mk(0, '0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 400; i++) begin
      s.run  = ($urandom_range(0, 7) != 0);
      s.ev   = NC'($urandom);
      s.en   = NC'($urandom) | NC'($urandom);
      s.ret  = $urandom_range(0, 1) != 0;
      s.clr  = ($urandom_range(0, 31) == 0);
      s.snap = ($urandom_range(0, 5) == 0);
      s.rdEn = $urandom_range(0, 1) != 0;
      s.addr = AW'($urandom);
      s.mask = TOT'($urandom);
      applyStimulus(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule

// File: doc/pmc_array.md
# pmc_array

Parametrised performance-monitoring counter array for the pipelined core. It counts per-class event strobes from the execute stage, along with core cycles and retired instructions, and keeps a sticky overflow flag per counter. An atomic snapshot copies all live counters into a shadow bank, and a 1-cycle-latency read port serves values from that bank. It sits beside the pipeline and supersedes the fixed-function instruction-class counters; CPI is computed by software from the cycle and retired readouts.

## Interface
Parameters:
- NUM_CNT, 18, number of event counters (one per instruction class).
- CNT_W, 32, counter width in bits; legal range 8..64.
- SATURATE, 0, overflow policy: 0 = wrap to zero, 1 = hold at all-ones.
- Derived localparam ADDR_W = $clog2(NUM_CNT+2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run_i  in  1  global count enable.
- event_i  in  NUM_CNT  one-cycle event strobes; bit k drives counter k.
- cnt_en_i  in  NUM_CNT  per-counter enable mask.
- retire_i  in  1  instruction-retired strobe.
- clear_i  in  1  synchronous clear of all live counters and overflow flags.
- snap_req_i  in  1  snapshot request.
- snap_done_o  out  1  one-cycle pulse after the shadow bank is updated.
- rd_en_i  in  1  read strobe.
- rd_addr_i  in  ADDR_W  shadow index.
- rd_data_o  out  CNT_W  read data.
- rd_valid_o  out  1  read data valid.
- ovf_o  out  NUM_CNT+2  sticky overflow flags, using read-address order.
- irq_o  out  1  overflow interrupt; present only with PMC_OVF_IRQ_EN.
- ovf_mask_i  in  NUM_CNT+2  interrupt mask; present only with PMC_OVF_IRQ_EN.

## Operation
- Index map:
  - 0..NUM_CNT-1: event counters.
  - NUM_CNT: cycle counter.
  - NUM_CNT+1: retired counter.
  - Higher addresses read as 0 with rd_valid_o still asserted.
- Increment conditions, each at most +1 per cycle:
  - Event counter k: run_i & cnt_en_i[k] & event_i[k].
  - Cycle counter: run_i.
  - Retired counter: run_i & retire_i.
- Overflow is an increment from all-ones. It sets the counter's ovf bit, which stays set until clear_i or reset.
  - SATURATE=0: counter becomes 0.
  - SATURATE=1: counter holds all-ones and ignores further increments.
- Snapshot FSM has two states:
  - IDLE: on snap_req_i, copy every live counter value into the shadow bank at that edge and go to DONE. The copied value is the pre-increment value of that cycle.
  - DONE: assert snap_done_o for one cycle, then return to IDLE. A snap_req_i received in DONE is ignored.
- clear_i together with an increment: clear wins and the counter becomes 0.
- clear_i together with snap_req_i: the shadow bank captures the pre-clear values and the live counters clear. This supports interval sampling.
- The shadow bank is never cleared by clear_i; only reset clears it.
- Read during the snapshot edge: returns the old shadow value. The new value is visible from the next read.

## Timing
- Reset (async assert, sync deassert assumed at source) sets all counters, shadows, ovf_o, rd_data_o, rd_valid_o, snap_done_o, irq_o and the FSM state (IDLE) to 0.
- Increments are visible on the counter output on the cycle after the strobe.
- Read latency is 1: rd_en_i at edge N gives rd_data_o and rd_valid_o at N+1. rd_valid_o is a 1-cycle pulse per read. Back-to-back reads are allowed every cycle.
- snap_req_i at edge N: shadow updated at N, snap_done_o high during cycle N+1. The next accepted request is at N+2.
- irq_o is registered: it goes high one cycle after any (ovf_o & ovf_mask_i) bit becomes set.

## Configuration
- PMC_OVF_IRQ_EN defined: ovf_mask_i and a registered irq_o are present; irq_o = |(ovf_o & ovf_mask_i).
- PMC_OVF_IRQ_EN undefined: both ports and the interrupt logic are absent. ovf_o is still produced.

## Structure
- Shared package pmc_pkg holds:
  - Event index enum: ADD, SUB, ADDI, ADD_FP, MUL_FP, VADD_FP, VMUL_FP, VSUM_FP, VSET_FP, SW, LW, SW_FP, LW_FP, VST, VLD, BEQ, BLT, J.
  - Localparams for the cycle and retired indices.
  - Snapshot FSM state typedef.
- Sub-module pmc_counter holds one counter plus its ovf flag, with inputs inc, clr and a SATURATE/CNT_W parameter. It is instantiated NUM_CNT+2 times by generate.

## Test plan
- Reset mid-count: counters at 5, reset low → all outputs 0 asynchronously; after release, counting resumes from 0.
- run_i=1 for 20 cycles, event_i[3] on 7 of them, retire_i on 12, cnt_en_i all ones → snapshot, then read 3, NUM_CNT, NUM_CNT+1 → 7, 20, 12, each with 1-cycle latency.
- cnt_en_i[3]=0 or run_i=0 with strobes active → counter 3 and cycle counter unchanged.
- CNT_W=8, SATURATE=0, 256 events on counter 0 → counter reads 0 and ovf_o[0]=1. With SATURATE=1 → reads 255 after 300 events and ovf_o[0]=1.
- clear_i and snap_req_i in the same cycle with counter 1 = 9 → shadow reads 9, live counter 0, snap_done_o pulses next cycle; snap_req_i during DONE is ignored.
- With PMC_OVF_IRQ_EN: overflow on counter 2 with mask bit 2 = 0 → irq_o stays 0. Set mask bit 2 = 1 → irq_o = 1 after one cycle; clear_i → irq_o = 0.
